// File: rtl/obuf_drain.sv
// obuf_drain: OBUF read-side drain engine.
// Turns (start_addr, num_words) into a credit-limited, back-pressurable stream.
module obuf_drain #(
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int MEM_DATA_WIDTH = 64,
    parameter int COUNT_W        = 16,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [MEM_ADDR_WIDTH-1:0] start_addr,
    input  logic [COUNT_W-1:0]        num_words,
    output logic                      busy,
    output logic                      done,
    output logic                      mem_read_req,
    output logic [MEM_ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [MEM_DATA_WIDTH-1:0] mem_read_data,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [MEM_DATA_WIDTH-1:0] m_data,
    output logic                      m_last
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [MEM_ADDR_WIDTH-1:0] rd_addr;
    logic [MEM_ADDR_WIDTH-1:0] last_addr;
    logic [COUNT_W-1:0]        rd_remaining;
    logic [COUNT_W-1:0]        out_remaining;
    logic                      inflight;

    logic [MEM_DATA_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]          wr_ptr;
    logic [PTR_W-1:0]          rd_ptr;
    logic [PTR_W:0]            fifo_count;
    logic [PTR_W+1:0]          credit_used;

    logic issue;
    logic accept;
    logic push;
    logic pop;
    logic drain_done;

    assign accept      = (state == IDLE) && start;
    assign credit_used = {1'b0, fifo_count} + (PTR_W+2)'(inflight);
    assign issue       = (state == READ)
                       && (rd_remaining != '0)
                       && (credit_used < (PTR_W+2)'(FIFO_DEPTH));

    // A read returns exactly one cycle after its request.
    assign push = inflight;
    assign pop  = m_valid && m_ready;

    assign mem_read_req  = issue;
    assign mem_read_addr = issue ? rd_addr : last_addr;

    assign m_valid = (fifo_count != '0);
    assign m_data  = m_valid ? fifo_mem[rd_ptr] : '0;
    assign m_last  = m_valid && (out_remaining == COUNT_W'(1));

    // Finish in the cycle the final beat handshakes, or at once if nothing is owed.
    assign drain_done = (pop && (out_remaining == COUNT_W'(1)))
                      || ((out_remaining == '0) && (fifo_count == '0) && !inflight);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status decode; a zero-word command still shows one busy cycle.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_next = (num_words == '0) ? DRAIN : READ;
                end
            end
            READ: begin
                busy = 1'b1;
                if (issue && (rd_remaining == COUNT_W'(1))) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (drain_done) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                done       = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

    // Read address, remaining counts and the one-deep in-flight marker.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_addr       <= '0;
            last_addr     <= '0;
            rd_remaining  <= '0;
            out_remaining <= '0;
            inflight      <= 1'b0;
        end else begin
            inflight <= issue;
            if (accept) begin
                rd_addr       <= start_addr;
                rd_remaining  <= num_words;
                out_remaining <= num_words;
            end else begin
                if (issue) begin
                    rd_addr      <= rd_addr + MEM_ADDR_WIDTH'(1);
                    rd_remaining <= rd_remaining - COUNT_W'(1);
                    last_addr    <= rd_addr;
                end
                if (pop) begin
                    out_remaining <= out_remaining - COUNT_W'(1);
                end
            end
        end
    end

    // FIFO storage; contents need no reset since occupancy is tracked separately.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= mem_read_data;
        end
    end

    // FIFO pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({push, pop})
                2'b10:   fifo_count <= fifo_count + (PTR_W+1)'(1);
                2'b01:   fifo_count <= fifo_count - (PTR_W+1)'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

endmodule
